load_use_scoreboard: RTL and testbench
======================================

# load_use_scoreboard

Tracks in-flight load instructions through the multi-stage data-memory pipeline (MEM1..MEMn) and consumes their destination registers to detect load-use hazards against the instruction in ID. Asserts a same-cycle stall to the fetch/decode stages and injects bubbles until load data reaches the bypass point. Sits beside the ID/MEM pipeline buffers and replaces ad-hoc MemRead/rd comparisons in the hazard logic.

## Interface
- MEM_STAGES, 2: number of memory pipeline stages a load occupies before its data is forwardable (legal 1..4)
- REG_W, 5: register index width
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1, i_id_rs2  in  REG_W  source register indices of ID instruction
- i_id_use_rs1, i_id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- i_id_memread  in  1  ID instruction is a load
- i_id_rd  in  REG_W  ID destination register
- i_flush  in  1  kill the ID instruction this cycle (branch redirect)
- o_stall  out  1  hold PC and IF/ID this cycle
- o_bubble  out  1  ID instruction not issued this cycle (stall or flush)
- o_wb_load_valid  out  1  a load leaves the final memory stage this cycle
- o_wb_load_rd  out  REG_W  its destination register
- o_fwd_rs1, o_fwd_rs2  out  1  ID source must take the load-bypass path this cycle

## Operation
- Scoreboard: shift register of MEM_STAGES entries {valid, rd}; entry 0 = MEM1, entry MEM_STAGES-1 = last memory stage.
- Entries shift every cycle unconditionally; memory pipeline never stalls on this block.
- Entry 0 next = {1, i_id_rd} iff i_id_valid & i_id_memread & (i_id_rd != 0) & ~o_stall & ~i_flush; else {0, 0}.
- Hazard for rsX: i_id_valid & i_id_use_rsX & (i_id_rsX != 0) & match against any valid entry k, 0 <= k < MEM_STAGES-1... plus the incoming MEM1 slot is covered because ID compares only against already-registered entries.
- o_stall = hazard_rs1 | hazard_rs2, gated low when i_flush = 1 (flush wins; the killed instruction needs no operands).
- o_bubble = o_stall | i_flush.
- o_fwd_rsX = i_id_valid & i_id_use_rsX & (i_id_rsX != 0) & o_wb_load_valid & (o_wb_load_rd == i_id_rsX) & ~o_stall.
- o_wb_load_valid/o_wb_load_rd = last entry, registered.
- Multiple matching entries (same rd in flight twice): youngest-match irrelevant for stall; any match stalls.
- Register x0 never tracked, never matched.

## Timing
- o_stall, o_bubble, o_fwd_* combinational from ID inputs and registered state; same-cycle.
- Load issued from ID at cycle T: in entry 0 at T+1, last entry/o_wb_load_valid at T+MEM_STAGES.
- Dependent instruction directly behind a load stalls MEM_STAGES-1 cycles, then issues with o_fwd set (MEM_STAGES=1: zero stall, forward at T+1).
- Reset: all entries {0,0}; o_wb_load_valid=0, o_wb_load_rd=0; o_stall/o_bubble/o_fwd_* = 0 while ID inputs idle. Reset mid-operation discards all in-flight loads next cycle.
- Stall does not freeze the scoreboard; bubble entries shift in behind draining loads.

## Configuration
- LOAD_USE_SCOREBOARD_STATS_EN defined: adds output o_stall_cnt (32 bits), increments each cycle o_stall=1, saturates at 0xFFFFFFFF, cleared by i_rst.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package holds REG_W default, the scoreboard entry struct {valid, rd}, and MEM_STAGES default.
- One sub-module, sb_match: compares one source index against all entries, returns hit vector; instantiated twice (rs1, rs2).

## Test plan
- Reset then idle -> all outputs 0 for 5 cycles; o_wb_load_rd=0.
- MEM_STAGES=2: load rd=5, next instr rs1=5 use_rs1=1 -> o_stall=1 one cycle, then o_fwd_rs1=1, o_stall=0.
- Load rd=0 followed by rs1=0 user -> no stall, no forward, o_wb_load_valid stays 0.
- Dependent instr stalled with i_flush=1 same cycle -> o_stall=0, o_bubble=1, entry 0 empty next cycle.
- Two back-to-back loads rd=3, rd=4, then instr rs1=3 rs2=4 -> stall until both clear; o_fwd_rs2=1 on issue cycle.
- i_rst mid-stall with load rd=7 in entry 0 -> next cycle o_stall=0, o_wb_load_valid never asserts for rd=7; with STATS_EN, o_stall_cnt=0.

Source files
------------

// File: rtl/load_use_scoreboard_pkg.sv
// load_use_scoreboard_pkg: shared defaults and the scoreboard entry type
package load_use_scoreboard_pkg;
  localparam int SB_REG_W = 5;
  localparam int SB_MEM_STAGES = 2;
  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
  } sb_entry_t;
endpackage

// File: rtl/load_use_scoreboard_sb_match.sv
// sb_match: compares one ID source index against every in-flight load entry
module sb_match
  import load_use_scoreboard_pkg::*;
#(
  parameter int N = SB_MEM_STAGES
) (
  input  logic                i_req,
  input  logic [SB_REG_W-1:0] i_idx,
  input  sb_entry_t [N-1:0]   i_ents,
  output logic [N-1:0]        o_hit
);
  // x0 is hardwired zero, so it never matches a tracked load
  always_comb begin
    for (int k = 0; k < N; k++) o_hit[k] = i_req & (i_idx != '0) & i_ents[k].valid & (i_ents[k].rd == i_idx);
  end
endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard stall/bubble/forward control; LOAD_USE_SCOREBOARD_STATS_EN adds o_stall_cnt
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int MEM_STAGES = SB_MEM_STAGES,
  parameter int REG_W      = SB_REG_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_memread,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_wb_load_valid,
  output logic [REG_W-1:0] o_wb_load_rd,
  output logic             o_fwd_rs1,
  output logic             o_fwd_rs2
`ifdef LOAD_USE_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);
  // only stages before the last still lack data; the last stage feeds the bypass
  localparam logic [MEM_STAGES-1:0] chk_mask = {MEM_STAGES{1'b1}} >> 1;
  sb_entry_t [MEM_STAGES-1:0] ents_q, ents_d;
  logic [MEM_STAGES-1:0] hit_rs1, hit_rs2;
  sb_match #(.N(MEM_STAGES)) u_match_rs1 (
    .i_req  (i_id_valid & i_id_use_rs1),
    .i_idx  (i_id_rs1),
    .i_ents (ents_q),
    .o_hit  (hit_rs1)
  );
  sb_match #(.N(MEM_STAGES)) u_match_rs2 (
    .i_req  (i_id_valid & i_id_use_rs2),
    .i_idx  (i_id_rs2),
    .i_ents (ents_q),
    .o_hit  (hit_rs2)
  );
  assign o_stall         = (|((hit_rs1 | hit_rs2) & chk_mask)) & ~i_flush;
  assign o_bubble        = o_stall | i_flush;
  assign o_fwd_rs1       = hit_rs1[MEM_STAGES-1] & ~o_stall;
  assign o_fwd_rs2       = hit_rs2[MEM_STAGES-1] & ~o_stall;
  assign o_wb_load_valid = ents_q[MEM_STAGES-1].valid;
  assign o_wb_load_rd    = ents_q[MEM_STAGES-1].rd;
  // an issuing load enters MEM1 while older entries advance unconditionally
  always_comb begin
    ents_d[0] = (i_id_valid & i_id_memread & (i_id_rd != '0) & ~o_stall & ~i_flush) ? {1'b1, i_id_rd} : '0;
    for (int k = 1; k < MEM_STAGES; k++) ents_d[k] = ents_q[k-1];
  end
  // scoreboard shift register; reset discards every in-flight load
  always_ff @(posedge i_clk) ents_q <= i_rst ? '0 : ents_d;
`ifdef LOAD_USE_SCOREBOARD_STATS_EN
  // saturating count of stall cycles
  always_ff @(posedge i_clk) o_stall_cnt <= i_rst ? '0 : o_stall_cnt + {31'd0, o_stall & ~&o_stall_cnt};
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed stimulus with a writeback scoreboard for load_use_scoreboard
module tb_load_use_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, use_rs1, use_rs2, memread, flush;
  logic [4:0] rs1, rs2, rd;
  logic       stall, bubble, wb_valid, fwd_rs1, fwd_rs2;
  logic [4:0] wb_rd;
`ifdef LOAD_USE_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
`endif
  typedef struct {
    logic [4:0] rd;
    int         cyc;
  } wb_exp_t;
  wb_exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  load_use_scoreboard dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_valid      (id_valid),
    .i_id_rs1        (rs1),
    .i_id_rs2        (rs2),
    .i_id_use_rs1    (use_rs1),
    .i_id_use_rs2    (use_rs2),
    .i_id_memread    (memread),
    .i_id_rd         (rd),
    .i_flush         (flush),
    .o_stall         (stall),
    .o_bubble        (bubble),
    .o_wb_load_valid (wb_valid),
    .o_wb_load_rd    (wb_rd),
    .o_fwd_rs1       (fwd_rs1),
    .o_fwd_rs2       (fwd_rs2)
`ifdef LOAD_USE_SCOREBOARD_STATS_EN
    ,
    .o_stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {stall, bubble, fwd_rs1, fwd_rs2}
  task automatic exp_ctl(input string tag, input logic [3:0] e);
    check(tag, 64'({stall, bubble, fwd_rs1, fwd_rs2}), 64'(e));
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic u1, input logic u2,
                       input logic mr, input logic [4:0] d, input logic fl);
    id_valid = v; rs1 = s1; rs2 = s2; use_rs1 = u1; use_rs2 = u2; memread = mr; rd = d; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a load issued in cycle c must appear at writeback in cycle c+2
  task automatic push_load(input logic [4:0] d);
    q.push_back('{rd: d, cyc: cyc + 2});
  endtask

  // every writeback must match the oldest expected load, in rd and arrival cycle
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      wb_exp_t e;
      e = (q.size() != 0) ? q.pop_front() : '{rd: 5'd0, cyc: 0};
      check("wb_load", {27'd0, wb_rd, cyc}, {27'd0, e.rd, e.cyc});
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_idle", 64'({stall, bubble, fwd_rs1, fwd_rs2, wb_valid, wb_rd}), 64'd0);
    end
    // load x5 followed by a user of x5: one stall, then forward
    drive(1, 0, 0, 0, 0, 1, 5, 0);
    exp_ctl("load5_issue", 4'b0000);
    push_load(5);
    tick();
    drive(1, 5, 0, 1, 0, 0, 9, 0);
    exp_ctl("use5_stall", 4'b1100);
    tick();
    exp_ctl("use5_fwd", 4'b0010);
    check("use5_wb", 64'({wb_valid, wb_rd}), 64'({1'b1, 5'd5}));
    tick();
    idle();
    tick();
    // load into x0 is never tracked
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 2, 0);
    exp_ctl("x0_nostall", 4'b0000);
    tick();
    idle();
    check("x0_nowb1", 64'(wb_valid), 64'd0);
    tick();
    check("x0_nowb2", 64'(wb_valid), 64'd0);
    // flushed dependent load (rd x8) must not stall nor enter the scoreboard
    drive(1, 0, 0, 0, 0, 1, 6, 0);
    push_load(6);
    tick();
    drive(1, 0, 6, 0, 1, 1, 8, 1);
    exp_ctl("flush_wins", 4'b0100);
    tick();
    drive(1, 8, 6, 1, 1, 0, 0, 0);
    exp_ctl("flush_entry_empty", 4'b0001);
    tick();
    idle();
    tick();
    // back-to-back loads x3, x4 then a user of both
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    push_load(3);
    tick();
    drive(1, 0, 0, 0, 0, 1, 4, 0);
    exp_ctl("load4_issue", 4'b0000);
    push_load(4);
    tick();
    drive(1, 3, 4, 1, 1, 0, 10, 0);
    exp_ctl("b2b_stall", 4'b1100);
    tick();
    exp_ctl("b2b_fwd_rs2", 4'b0001);
    tick();
    idle();
    tick();
    // reset while a dependent of load x7 is stalled
    drive(1, 0, 0, 0, 0, 1, 7, 0);
    tick();
    drive(1, 7, 0, 1, 0, 0, 11, 0);
    exp_ctl("rst_pre_stall", 4'b1100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ctl("rst_cleared", 4'b0000);
`ifdef LOAD_USE_SCOREBOARD_STATS_EN
    check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_wb7", 64'(wb_valid), 64'd0);
    end
    idle();
    tick();
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
